ad7643_multi_reader: RTL and testbench
======================================

Name: ad7643_multi_reader

Overview:
- Parametrised successor to the single-channel AD7643 serial-slave readout.
- Drives NCH ADCs that share CS/SCLK and have per-channel CNVST, BUSY and SDOUT lines.
- Assembles one DBITS-wide sample per channel into a frame and delivers it on a valid/ready stream to the memory/USB write path.
- Adds single-shot and periodic modes, BUSY timeouts, and overrun accounting.

Parameters:
- NCH, 2: number of ADC channels (1..8).
- DBITS, 18: bits per conversion, shifted MSB first.
- CNV_CYC, 4: CNVST high width in CLK cycles (min 1).
- SCLK_DIV, 2: CLK cycles per SCLK half-period (min 1).
- PERIOD, 250: CLK cycles between conversion starts in periodic mode.
- BUSY_TO, 255: maximum CLK cycles allowed for each BUSY phase before timeout.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  enable; low means no new conversion starts.
- MODE  in  1  0 = single-shot on TRIG, 1 = periodic every PERIOD cycles.
- TRIG  in  1  single-cycle start pulse, used when MODE = 0.
- ERR_CLR  in  1  clears the ERR flags.
- ADCNVST  out  NCH  convert start, per channel.
- ADCS  out  1  shared chip select, active-low.
- ADSCLK  out  1  shared serial clock.
- ADBUSY  in  NCH  ADC busy, per channel.
- ADSDOUT  in  NCH  serial data, per channel.
- SMP_DATA  out  NCH*DBITS  frame; channel k occupies bits [k*DBITS +: DBITS].
- SMP_VALID  out  1  frame valid.
- SMP_READY  in  1  consumer accepts the frame.
- SMP_SEQ  out  16  frame sequence number; wraps 0xFFFF to 0.
- OVERRUN  out  8  count of dropped frames; saturates at 255.
- ERR  out  2  sticky flags: [0] BUSY-rise timeout, [1] BUSY-fall timeout.
- ACTIVE  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; ADCNVST = 0; ADCS = 1; ADSCLK = 0; SMP_DATA = 0; SMP_VALID = 0; SMP_SEQ = 0; OVERRUN = 0; ERR = 0; period timer = 0.
- Start condition: EN = 1 and either (MODE = 0 and TRIG = 1) or (MODE = 1 and period timer = 0).
  - Period timer counts 0..PERIOD-1 while EN = 1 and MODE = 1; otherwise it is held at 0.
  - A start falling due while the FSM is busy is deferred: the FSM restarts the next cycle it reaches IDLE. Frame time > PERIOD therefore stretches spacing; it never causes a skip.
  - TRIG pulses that arrive while not IDLE are ignored.
- FSM:
  - IDLE -> CNV on start.
  - CNV: all ADCNVST = 1 for CNV_CYC cycles -> WBH.
  - WBH: wait until all ADBUSY = 1. Timeout after BUSY_TO cycles: set ERR[0], go to IDLE, no frame, SEQ unchanged.
  - WBH -> WBL when all BUSY are high.
  - WBL: wait until all ADBUSY = 0. Timeout after BUSY_TO cycles: set ERR[1], go to IDLE.
  - WBL -> SHIFT: ADCS = 0 on entry.
  - SHIFT: ADSCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles, repeated DBITS times.
    - Each ADSDOUT[k] is sampled on the last CLK cycle of each high phase and shifted into shift register k, MSB first.
    - After bit DBITS: ADCS = 1, ADSCLK = 0 -> STORE.
  - STORE: one cycle, then -> IDLE.
    - If SMP_VALID = 0, or SMP_READY = 1 in this same cycle: load SMP_DATA, set SMP_VALID = 1, SMP_SEQ += 1.
    - Otherwise: discard the new frame, OVERRUN += 1 (saturating), SMP_SEQ += 1 (the gap in SEQ shows the loss).
- Stream: SMP_VALID falls the cycle after SMP_VALID & SMP_READY, except when STORE reloads it in that same cycle. SMP_DATA stays stable while VALID = 1 and READY = 0.
- Latency from start to VALID: CNV_CYC + BUSY phases + 2*SCLK_DIV*DBITS + 1 cycles.
- EN falling mid-frame: the current frame completes normally; no new start.
- ERR_CLR clears ERR. If a timeout is detected in the same cycle as ERR_CLR, the set wins.

Decomposition:
- Package ad_pkg: FSM state enum (IDLE, CNV, WBH, WBL, SHIFT, STORE), ERR bit index constants, SEQ/OVERRUN widths.
- Sub-module ad_serial_shift: DBITS-wide MSB-first shift register with a sample-enable input; instantiated NCH times under generate.
- Top level contains the FSM, period timer, SCLK divider and output register.

Test Plan:
- Single shot, NCH = 2, DBITS = 18: ADC models return 0x2A5A5 / 0x15A5A with BUSY high for 160 cycles. Required: SMP_DATA = {0x15A5A, 0x2A5A5}, VALID after the computed latency, SEQ = 1, ERR = 0.
- Periodic, PERIOD = 250, READY = 1, BUSY = 100: 4 frames with consecutive CNVST rises exactly 250 cycles apart. Repeat with BUSY = 200: rises spaced by frame time (> 250), no frames skipped.
- Backpressure: READY = 0 for 3 frames -> first frame held unchanged, OVERRUN = 2, SEQ = 3. Then READY = 1 -> VALID falls, next frame arrives with SEQ = 4.
- ADBUSY[1] stuck at 0 -> ERR = 2'b01 after CNV_CYC + 255 cycles, FSM back in IDLE, no VALID. ERR_CLR -> ERR = 0.
- ADBUSY[0] stuck at 1 -> ERR[1] set, no frame. Next trigger with healthy models yields a correct frame.
- RST_N low mid-SHIFT (bit 9) -> outputs take reset values immediately. After release, a single shot yields a correct frame with SEQ = 1.

Source files
------------

// File: rtl/ad7643_multi_reader_pkg.sv
// ad_pkg: shared types and constants for the multi-channel AD7643 reader.
//   ad_state_t     : readout FSM states
//   ERR_RISE/FALL  : bit positions in the sticky ERR vector
//   SEQ_W / OVR_W  : widths of the frame sequence and overrun counters
package ad_pkg;
    typedef enum logic [2:0] {IDLE, CNV, WBH, WBL, SHIFT, STORE} ad_state_t;

    localparam int ERR_RISE = 0;   // BUSY never went high on all channels
    localparam int ERR_FALL = 1;   // BUSY never went low on all channels
    localparam int SEQ_W    = 16;
    localparam int OVR_W    = 8;
endpackage

// File: rtl/ad7643_multi_reader_shift.sv
// ad_serial_shift: DBITS-wide MSB-first deserializer for one ADC channel.
//   clk, rst_n : clock, async active-low reset
//   sample_en  : shift din in on this cycle
//   din        : serial data from the ADC
//   dout       : assembled word (first bit received ends up at the MSB)
module ad_serial_shift #(
    parameter int DBITS = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic             din,
    output logic [DBITS-1:0] dout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= '0;
        else if (sample_en)
            // shift form also works for DBITS = 1
            dout <= (dout << 1) | DBITS'(din);
    end
endmodule

// File: rtl/ad7643_multi_reader.sv
// ad7643_multi_reader: drives NCH AD7643 ADCs sharing CS/SCLK, collects one
// DBITS sample per channel into a frame and offers it on a valid/ready stream.
//   CLK, RST_N          : clock, async active-low reset
//   EN, MODE, TRIG      : start control (MODE 0 single-shot on TRIG, 1 periodic)
//   ERR_CLR             : clears sticky ERR
//   ADCNVST/ADCS/ADSCLK : ADC control outputs
//   ADBUSY/ADSDOUT      : per-channel ADC status and serial data
//   SMP_DATA/VALID/READY: frame stream, channel k at [k*DBITS +: DBITS]
//   SMP_SEQ, OVERRUN    : frame counter (counts dropped frames too), drop count
//   ERR, ACTIVE         : BUSY timeout flags, FSM busy indicator
module ad7643_multi_reader
    import ad_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int DBITS    = 18,
    parameter int CNV_CYC  = 4,
    parameter int SCLK_DIV = 2,
    parameter int PERIOD   = 250,
    parameter int BUSY_TO  = 255
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    input  logic                 MODE,
    input  logic                 TRIG,
    input  logic                 ERR_CLR,
    output logic [NCH-1:0]       ADCNVST,
    output logic                 ADCS,
    output logic                 ADSCLK,
    input  logic [NCH-1:0]       ADBUSY,
    input  logic [NCH-1:0]       ADSDOUT,
    output logic [NCH*DBITS-1:0] SMP_DATA,
    output logic                 SMP_VALID,
    input  logic                 SMP_READY,
    output logic [SEQ_W-1:0]     SMP_SEQ,
    output logic [OVR_W-1:0]     OVERRUN,
    output logic [1:0]           ERR,
    output logic                 ACTIVE
);
    ad_state_t                  state;
    logic [15:0]                cnt;     // CNV width / BUSY timeout counter
    logic [15:0]                dcnt;    // SCLK half-period divider
    logic [7:0]                 bcnt;    // bit index within the frame
    logic [15:0]                ptmr;    // period timer
    logic                       pend;    // periodic start fell due while busy
    logic                       tick;
    logic                       go;
    logic                       sample_en;
    logic [1:0]                 err_set;
    logic [NCH-1:0][DBITS-1:0]  shreg;

    assign tick      = EN && MODE && (ptmr == 16'd0);
    assign go        = EN && ((!MODE && TRIG) || (MODE && (tick || pend)));
    // ADC drives the bit while SCLK is high; take it on the last high cycle
    assign sample_en = (state == SHIFT) && ADSCLK && (dcnt == 16'(SCLK_DIV - 1));
    assign ACTIVE    = (state != IDLE);

    always_comb begin
        err_set           = '0;
        err_set[ERR_RISE] = (state == WBH) && !(&ADBUSY)      && (cnt == 16'(BUSY_TO - 1));
        err_set[ERR_FALL] = (state == WBL) && (ADBUSY != '0)  && (cnt == 16'(BUSY_TO - 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            ptmr <= '0;
        else if (EN && MODE)
            ptmr <= (ptmr == 16'(PERIOD - 1)) ? 16'd0 : ptmr + 16'd1;
        else
            ptmr <= '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ADCNVST <= '0;
            ADCS    <= 1'b1;
            ADSCLK  <= 1'b0;
            cnt     <= '0;
            dcnt    <= '0;
            bcnt    <= '0;
            pend    <= 1'b0;
            ERR     <= '0;
        end else begin
            // a timeout in the clearing cycle still lands
            ERR <= (ERR_CLR ? 2'b00 : ERR) | err_set;

            if (!(EN && MODE))
                pend <= 1'b0;
            else if (tick && state != IDLE)
                pend <= 1'b1;

            case (state)
                IDLE: if (go) begin
                    state   <= CNV;
                    ADCNVST <= '1;
                    cnt     <= '0;
                    pend    <= 1'b0;
                end
                CNV: if (cnt == 16'(CNV_CYC - 1)) begin
                    ADCNVST <= '0;
                    cnt     <= '0;
                    state   <= WBH;
                end else
                    cnt <= cnt + 16'd1;
                WBH: if (&ADBUSY) begin
                    cnt   <= '0;
                    state <= WBL;
                end else if (err_set[ERR_RISE])
                    state <= IDLE;
                else
                    cnt <= cnt + 16'd1;
                WBL: if (ADBUSY == '0) begin
                    ADCS   <= 1'b0;
                    ADSCLK <= 1'b0;
                    dcnt   <= '0;
                    bcnt   <= '0;
                    state  <= SHIFT;
                end else if (err_set[ERR_FALL])
                    state <= IDLE;
                else
                    cnt <= cnt + 16'd1;
                SHIFT: if (dcnt == 16'(SCLK_DIV - 1)) begin
                    dcnt <= '0;
                    if (!ADSCLK)
                        ADSCLK <= 1'b1;
                    else begin
                        ADSCLK <= 1'b0;
                        if (bcnt == 8'(DBITS - 1)) begin
                            ADCS  <= 1'b1;
                            state <= STORE;
                        end else
                            bcnt <= bcnt + 8'd1;
                    end
                end else
                    dcnt <= dcnt + 16'd1;
                STORE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: a frame finishing while the previous one is still
    // unaccepted is dropped, but still consumes a sequence number.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SMP_DATA  <= '0;
            SMP_VALID <= 1'b0;
            SMP_SEQ   <= '0;
            OVERRUN   <= '0;
        end else if (state == STORE) begin
            SMP_SEQ <= SMP_SEQ + SEQ_W'(1);
            if (!SMP_VALID || SMP_READY) begin
                SMP_DATA  <= shreg;
                SMP_VALID <= 1'b1;
            end else if (OVERRUN != '1)
                OVERRUN <= OVERRUN + OVR_W'(1);
        end else if (SMP_VALID && SMP_READY)
            SMP_VALID <= 1'b0;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        ad_serial_shift #(.DBITS(DBITS)) u_shift (
            .clk       (CLK),
            .rst_n     (RST_N),
            .sample_en (sample_en),
            .din       (ADSDOUT[k]),
            .dout      (shreg[k])
        );
    end
endmodule

// File: tb/tb_ad7643_multi_reader.sv
module tb_ad7643_multi_reader;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0, MODE = 1'b0, TRIG = 1'b0, ERR_CLR = 1'b0;
    logic [1:0]  ADCNVST;
    logic        ADCS, ADSCLK;
    logic [1:0]  ADBUSY, ADSDOUT;
    logic [35:0] SMP_DATA;
    logic        SMP_VALID;
    logic        SMP_READY = 1'b0;
    logic [15:0] SMP_SEQ;
    logic [7:0]  OVERRUN;
    logic [1:0]  ERR;
    logic        ACTIVE;

    ad7643_multi_reader #(.NCH(2), .DBITS(18), .CNV_CYC(4), .SCLK_DIV(2),
                          .PERIOD(250), .BUSY_TO(255)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .TRIG(TRIG),
        .ERR_CLR(ERR_CLR), .ADCNVST(ADCNVST), .ADCS(ADCS), .ADSCLK(ADSCLK),
        .ADBUSY(ADBUSY), .ADSDOUT(ADSDOUT), .SMP_DATA(SMP_DATA),
        .SMP_VALID(SMP_VALID), .SMP_READY(SMP_READY), .SMP_SEQ(SMP_SEQ),
        .OVERRUN(OVERRUN), .ERR(ERR), .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;

    // ADC model: BUSY high for bl cycles after CNVST rises, data MSB first,
    // next bit presented after each SCLK fall.
    logic [17:0] word0 = '0, word1 = '0;
    int          bl = 10;
    int          force_m [2] = '{0, 0};   // 0 model, 1 stuck low, 2 stuck high
    int          busy_m = 0, nfall = 0, cyc = 0;
    logic        cnv_q = 1'b0, sclk_q = 1'b0;
    int          rises [$];

    always @(negedge CLK) begin
        cyc++;
        if (ADCNVST[0] && !cnv_q) begin
            busy_m = bl;
            rises.push_back(cyc);
        end else if (busy_m > 0)
            busy_m--;
        cnv_q = ADCNVST[0];
        if (ADCS) nfall = 0;
        else if (sclk_q && !ADSCLK) nfall++;
        sclk_q = ADSCLK;
    end

    always_comb begin
        ADSDOUT = '0;
        if (nfall < 18) begin
            ADSDOUT[0] = word0[17 - nfall];
            ADSDOUT[1] = word1[17 - nfall];
        end
        for (int k = 0; k < 2; k++)
            ADBUSY[k] = (force_m[k] == 1) ? 1'b0 : (force_m[k] == 2) ? 1'b1 : (busy_m > 0);
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; EN = 1'b0; MODE = 1'b0; TRIG = 1'b0; ERR_CLR = 1'b0;
        force_m[0] = 0; force_m[1] = 0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic trig();
        EN = 1'b1; MODE = 1'b0; TRIG = 1'b1;
        tick();
        TRIG = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!SMP_VALID && n < 2000) begin tick(); n++; end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (ACTIVE && n < 2000) begin tick(); n++; end
        chk(name, ACTIVE, 0);
    endtask

    task automatic run_periodic(input int busy_len, input int exp_gap);
        int n = 0;
        do_reset();
        bl = busy_len; SMP_READY = 1'b1;
        rises.delete();
        EN = 1'b1; MODE = 1'b1;
        while (rises.size() < 4 && n < 3000) begin tick(); n++; end
        EN = 1'b0;
        wait_idle("per_idle");
        chk("per_nrises", rises.size(), 4);
        for (int i = 1; i < 4; i++)
            if (i < rises.size()) chk($sformatf("per_gap%0d", i), rises[i] - rises[i-1], exp_gap);
        chk("per_seq", SMP_SEQ, 4);
        chk("per_ovr", OVERRUN, 0);
    endtask

    typedef struct {
        logic [17:0] w0, w1;
        int          bl;
        logic [35:0] exp_data;
        int          exp_lat;
    } vec_t;
    vec_t vt [3];

    initial begin
        int n;
        vt[0] = '{18'h2A5A5, 18'h15A5A, 160, 36'h5696AA5A5, 234};
        vt[1] = '{18'h3FFFF, 18'h00000, 10,  36'h00003FFFF, 84};
        vt[2] = '{18'h00001, 18'h20000, 40,  36'h800000001, 114};

        // reset state
        tick();
        chk("rst_cnvst", ADCNVST, 0); chk("rst_cs", ADCS, 1); chk("rst_sclk", ADSCLK, 0);
        chk("rst_valid", SMP_VALID, 0); chk("rst_seq", SMP_SEQ, 0); chk("rst_data", SMP_DATA, 0);
        chk("rst_ovr", OVERRUN, 0); chk("rst_err", ERR, 0); chk("rst_active", ACTIVE, 0);
        do_reset();

        // single-shot table
        SMP_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word0 = vt[i].w0; word1 = vt[i].w1; bl = vt[i].bl;
            trig();
            wait_valid(n);
            chk($sformatf("ss%0d_lat", i), n, vt[i].exp_lat);
            chk($sformatf("ss%0d_data", i), SMP_DATA, vt[i].exp_data);
            chk($sformatf("ss%0d_seq", i), SMP_SEQ, i + 1);
            chk($sformatf("ss%0d_err", i), ERR, 0);
            tick();
            chk($sformatf("ss%0d_vfall", i), SMP_VALID, 0);
            wait_idle("ss_idle");
        end

        // periodic: exact period, then frame longer than period
        run_periodic(100, 250);
        run_periodic(200, 275);

        // backpressure
        do_reset();
        SMP_READY = 1'b0; bl = 10;
        word0 = 18'h11111; word1 = 18'h22222; trig(); wait_idle("bp_f1");
        word0 = 18'h33333; word1 = 18'h04444; trig(); wait_idle("bp_f2");
        word0 = 18'h05555; word1 = 18'h06666; trig(); wait_idle("bp_f3");
        chk("bp_valid", SMP_VALID, 1);
        chk("bp_data", SMP_DATA, 36'h888891111);
        chk("bp_ovr", OVERRUN, 2);
        chk("bp_seq", SMP_SEQ, 3);
        SMP_READY = 1'b1;
        tick();
        chk("bp_vfall", SMP_VALID, 0);
        word0 = 18'h0ABCD; word1 = 18'h01234; trig(); wait_idle("bp_f4");
        chk("bp4_valid", SMP_VALID, 1);
        chk("bp4_data", SMP_DATA, 36'h048D0ABCD);
        chk("bp4_seq", SMP_SEQ, 4);

        // BUSY[1] stuck low: rise timeout
        do_reset();
        bl = 160; force_m[1] = 1;
        trig();
        repeat (258) tick();
        chk("to_rise_early", ERR, 2'b00);
        tick();
        chk("to_rise_err", ERR, 2'b01);
        chk("to_rise_idle", ACTIVE, 0);
        chk("to_rise_novalid", SMP_VALID, 0);
        chk("to_rise_seq", SMP_SEQ, 0);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        chk("to_rise_clr", ERR, 2'b00);

        // BUSY[0] stuck high: fall timeout, then recovery
        force_m[1] = 0; force_m[0] = 2;
        trig();
        wait_idle("to_fall_idle");
        chk("to_fall_err", ERR, 2'b10);
        chk("to_fall_novalid", SMP_VALID, 0);
        force_m[0] = 0;
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        chk("to_fall_clr", ERR, 2'b00);
        SMP_READY = 1'b0; bl = 10;
        word0 = 18'h2A5A5; word1 = 18'h15A5A;
        trig(); wait_valid(n);
        chk("rec_lat", n, 84);
        chk("rec_data", SMP_DATA, 36'h5696AA5A5);
        chk("rec_seq", SMP_SEQ, 1);

        // reset during SHIFT (held frame pending, so reset is observable)
        word0 = 18'h3C3C3; word1 = 18'h0F0F0;
        trig();
        n = 0;
        while (ADCS && n < 500) begin tick(); n++; end
        repeat (36) tick();
        chk("mid_in_shift", ADCS, 0);
        RST_N = 1'b0;
        #1;
        chk("mid_cs", ADCS, 1); chk("mid_sclk", ADSCLK, 0); chk("mid_cnvst", ADCNVST, 0);
        chk("mid_valid", SMP_VALID, 0); chk("mid_seq", SMP_SEQ, 0); chk("mid_data", SMP_DATA, 0);
        chk("mid_active", ACTIVE, 0);
        tick();
        RST_N = 1'b1;
        tick();
        word0 = 18'h12345; word1 = 18'h2FEDC;
        trig(); wait_valid(n);
        chk("post_lat", n, 84);
        chk("post_data", SMP_DATA, 36'hBFB712345);
        chk("post_seq", SMP_SEQ, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
